// File: rtl/lsu_dmem_ctrl.sv
// lsu_dmem_ctrl: load/store unit that validates requests, drives the data memory's write-type port
// and returns a registered, sign/zero-extended response that is held under backpressure.
module lsu_dmem_ctrl #(
  parameter int DEPTH_WORDS = 64,
  parameter int FCNT_W      = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_fault,
  output logic [1:0]        resp_cause,
  output logic [FCNT_W-1:0] fault_cnt,
  output logic [1:0]        mem_we,
  output logic [31:0]       mem_a,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_rd
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t            state_q;
  logic              we_q, valid_q, fault_q;
  logic [2:0]        f3_q;
  logic [31:0]       addr_q, wdata_q, rdata_q, rdata_d;
  logic [1:0]        cause_q, cause_d;
  logic [FCNT_W-1:0] fcnt_q;
  logic              illegal, misal, oor, sx;
  logic [7:0]        b;
  logic [15:0]       h;
  // funct3[1:0] encodes access size (00 byte, 01 half, 10 word); funct3[2] marks unsigned loads
  always_comb begin
    illegal = we_q ? (f3_q[2] || f3_q[1:0] == 2'b11) : (f3_q[1:0] == 2'b11 || f3_q[2:1] == 2'b11);
    misal   = (f3_q[1:0] == 2'b01 && addr_q[0]) || (f3_q[1:0] == 2'b10 && addr_q[1:0] != 2'b00);
    oor     = addr_q >= 32'(DEPTH_WORDS * 4);
    cause_d = illegal ? 2'b01 : misal ? 2'b10 : oor ? 2'b11 : 2'b00;
    b       = 8'(mem_rd >> {addr_q[1:0], 3'b000});
    h       = addr_q[1] ? mem_rd[31:16] : mem_rd[15:0];
    sx      = !f3_q[2];
    rdata_d = (we_q || cause_d != 2'b00) ? 32'd0 :
              f3_q[1:0] == 2'b00 ? {{24{sx & b[7]}}, b} :
              f3_q[1:0] == 2'b01 ? {{16{sx & h[15]}}, h} : mem_rd;
    mem_we  = (state_q == ACCESS && we_q && cause_d == 2'b00) ?
              (f3_q[1:0] == 2'b00 ? 2'b11 : f3_q[1:0] == 2'b01 ? 2'b10 : 2'b01) : 2'b00;
  end
  assign req_ready  = state_q == IDLE;
  assign mem_a      = addr_q;
  assign mem_wd     = wdata_q;
  assign resp_valid = valid_q;
  assign resp_rdata = rdata_q;
  assign resp_fault = fault_q;
  assign resp_cause = cause_q;
  assign fault_cnt  = fcnt_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      cause_q <= 2'b00;
      rdata_q <= 32'd0;
      fcnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          we_q    <= req_we;
          f3_q    <= req_funct3;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          state_q <= ACCESS;
        end
        ACCESS: begin
          rdata_q <= rdata_d;
          fault_q <= cause_d != 2'b00;
          cause_q <= cause_d;
          valid_q <= 1'b1;
          if (cause_d != 2'b00 && !(&fcnt_q)) fcnt_q <= fcnt_q + 1'b1;
          state_q <= RESP;
        end
        RESP: if (resp_ready) begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// tb_lsu_dmem_ctrl: directed plus randomized checks of lsu_dmem_ctrl against a byte-level
// reference memory and an access-rule model.
module tb_lsu_dmem_ctrl;
  logic        clk = 1'b0, reset_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic        resp_valid, resp_ready = 1'b0, resp_fault;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_cause, mem_we;
  logic [7:0]  fault_cnt;
  logic [31:0] mem_a, mem_wd, mem_rd;
  logic [31:0] dmem [64];
  logic [31:0] ref_mem [64];
  int          ref_cnt = 0;
  int          checks = 0, errors = 0;

  lsu_dmem_ctrl #(.DEPTH_WORDS(64), .FCNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_fault(resp_fault), .resp_cause(resp_cause),
    .fault_cnt(fault_cnt), .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  // data memory: lane chosen by the low address bits
  assign mem_rd = dmem[mem_a[7:2]];
  always @(posedge clk) begin
    case (mem_we)
      2'b01: dmem[mem_a[7:2]] <= mem_wd;
      2'b10: dmem[mem_a[7:2]][16*mem_a[1] +: 16] <= mem_wd[15:0];
      2'b11: dmem[mem_a[7:2]][8*mem_a[1:0] +: 8] <= mem_wd[7:0];
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] er, output logic [1:0] ec, output logic [1:0] ewe);
    int     sz;
    bit     legal;
    longint v;
    sz    = 1 << f3[1:0];
    legal = we ? (f3 <= 2) : (f3 inside {0, 1, 2, 4, 5});
    ec    = !legal ? 2'd1 : (a % sz) != 0 ? 2'd2 : a >= 256 ? 2'd3 : 2'd0;
    er    = 0;
    ewe   = 0;
    if (ec != 0) begin
      if (ref_cnt < 255) ref_cnt++;
    end else if (we) begin
      for (int k = 0; k < sz; k++) ref_mem[(a + k) / 4][((a + k) % 4) * 8 +: 8] = wd[8*k +: 8];
      ewe = sz == 1 ? 2'd3 : sz == 2 ? 2'd2 : 2'd1;
    end else begin
      v = longint'(ref_mem[a / 4] >> ((a % 4) * 8));
      if (sz < 4) begin
        v = v % (longint'(1) << (8 * sz));
        if (f3 < 4 && v >= (longint'(1) << (8 * sz - 1))) v = v - (longint'(1) << (8 * sz));
      end
      er = 32'(v);
    end
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        input int hold);
    logic [31:0] er;
    logic [1:0]  ec, ewe;
    model(we, f3, a, wd, er, ec, ewe);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; resp_ready = 1'b0;
    check("req_ready_idle", 32'(req_ready), 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("mem_we", 32'(mem_we), 32'(ewe));
    check("mem_a", mem_a, a);
    if (ewe != 0) check("mem_wd", mem_wd, wd);
    @(posedge clk); #1;
    check("resp_valid", 32'(resp_valid), 1);
    check("resp_rdata", resp_rdata, er);
    check("resp_fault", 32'(resp_fault), 32'(ec != 0));
    check("resp_cause", 32'(resp_cause), 32'(ec));
    check("fault_cnt", 32'(fault_cnt), 32'(ref_cnt));
    check("mem_we_resp", 32'(mem_we), 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'd0; req_wdata = $urandom;
      @(posedge clk); #1;
      check("hold_valid", 32'(resp_valid), 1);
      check("hold_rdata", resp_rdata, er);
      check("hold_cause", 32'(resp_cause), 32'(ec));
      check("hold_ready", 32'(req_ready), 0);
    end
    @(negedge clk);
    req_valid = 1'b0; resp_ready = 1'b1;
    @(posedge clk); #1;
    check("done_valid", 32'(resp_valid), 0);
    check("done_ready", 32'(req_ready), 1);
    resp_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      dmem[i] = $urandom;
      ref_mem[i] = dmem[i];
    end
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(resp_valid), 0);
    check("rst_rdata", resp_rdata, 0);
    check("rst_fault", 32'(resp_fault), 0);
    check("rst_cause", 32'(resp_cause), 0);
    check("rst_fcnt", 32'(fault_cnt), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_a", mem_a, 0);
    @(negedge clk) reset_n = 1'b1;
    do_req(1, 3'd2, 32'h10, 32'hDEADBEEF, 0);
    do_req(0, 3'd2, 32'h10, 32'h0, 0);
    do_req(0, 3'd0, 32'h13, 32'h0, 0);
    do_req(0, 3'd4, 32'h13, 32'h0, 1);
    do_req(0, 3'd1, 32'h12, 32'h0, 0);
    do_req(0, 3'd5, 32'h10, 32'h0, 0);
    do_req(1, 3'd1, 32'h16, 32'h00001234, 0);
    do_req(0, 3'd2, 32'h14, 32'h0, 0);
    do_req(0, 3'd2, 32'h02, 32'h0, 0);
    do_req(1, 3'd2, 32'h100, 32'h55, 0);
    do_req(0, 3'd3, 32'h01, 32'h0, 0);
    check("fcnt_three", 32'(fault_cnt), 3);
    do_req(0, 3'd2, 32'h10, 32'h0, 5);
    // reset during the ACCESS cycle of a byte store must abort it
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h20; req_wdata = 32'hA5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("abort_mem_we_pre", 32'(mem_we), 3);
    reset_n = 1'b0;
    #1;
    check("abort_mem_we", 32'(mem_we), 0);
    check("abort_valid", 32'(resp_valid), 0);
    check("abort_fcnt", 32'(fault_cnt), 0);
    check("abort_ready", 32'(req_ready), 1);
    ref_cnt = 0;
    @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    check("abort_byte", dmem[8], ref_mem[8]);
    for (int n = 0; n < 700; n++)
      do_req(1'($urandom % 2), 3'($urandom % 8),
             ($urandom % 2) ? $urandom_range(0, 255) : $urandom_range(0, 511), $urandom, $urandom % 3);
    check("fcnt_sat", 32'(fault_cnt), 32'(ref_cnt));
    for (int i = 0; i < 64; i++) check("final_mem", dmem[i], ref_mem[i]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
